// File: rtl/vga_timing_pkg.sv
// 640x480@60 timing constants and the sync bundle that travels down the
// alignment pipe between the counters and the output register.
package vga_timing_pkg;

  localparam int unsigned CNT_W = 10;

  localparam int unsigned VGA_TOTAL_COLS    = 800;
  localparam int unsigned VGA_TOTAL_ROWS    = 525;
  localparam int unsigned VGA_ACTIVE_COLS   = 640;
  localparam int unsigned VGA_ACTIVE_ROWS   = 480;
  localparam int unsigned VGA_H_FRONT_PORCH = 16;
  localparam int unsigned VGA_H_SYNC_WIDTH  = 96;
  localparam int unsigned VGA_V_FRONT_PORCH = 10;
  localparam int unsigned VGA_V_SYNC_WIDTH  = 2;

  localparam int unsigned H_SYNC_START = VGA_ACTIVE_COLS + VGA_H_FRONT_PORCH;
  localparam int unsigned H_SYNC_END   = H_SYNC_START + VGA_H_SYNC_WIDTH;
  localparam int unsigned V_SYNC_START = VGA_ACTIVE_ROWS + VGA_V_FRONT_PORCH;
  localparam int unsigned V_SYNC_END   = V_SYNC_START + VGA_V_SYNC_WIDTH;

  // Raw, polarity-free decode of one count; polarity is applied at the output.
  typedef struct packed {
    logic hs;
    logic vs;
    logic act;
  } sync_bundle_t;

  localparam sync_bundle_t SYNC_IDLE = '{hs: 1'b0, vs: 1'b0, act: 1'b0};

  // Half-open window test lo <= v < hi on counter-width values.
  function automatic logic in_window(input logic [CNT_W-1:0] v,
                                     input logic [CNT_W-1:0] lo,
                                     input logic [CNT_W-1:0] hi);
    return (v >= lo) && (v < hi);
  endfunction

endpackage

// File: rtl/sync_delay_line.sv
// Fixed-depth shift register with async active-low reset to RESET_VAL;
// DEPTH = 0 degenerates to a wire.
module sync_delay_line
  import vga_timing_pkg::*;
#(
  parameter int unsigned       DEPTH     = 0,
  parameter int unsigned       WIDTH     = $bits(sync_bundle_t),
  parameter logic [WIDTH-1:0]  RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  if (DEPTH == 0) begin : g_pass
    logic unused_pass;
    assign unused_pass = clk & rst_n;
    assign dout        = din;
  end else begin : g_pipe
    logic [WIDTH-1:0] stage_q [DEPTH];
    logic [WIDTH-1:0] stage_d [DEPTH];

    always_comb begin
      stage_d[0] = din;
      for (int unsigned i = 1; i < DEPTH; i++) begin
        stage_d[i] = stage_q[i-1];
      end
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        for (int unsigned i = 0; i < DEPTH; i++) begin
          stage_q[i] <= RESET_VAL;
        end
      end else begin
        stage_q <= stage_d;
      end
    end

    assign dout = stage_q[DEPTH-1];
  end

endmodule

// File: rtl/vga_sync_gen.sv
// VGA timing generator: column/row counters, sync/active decode delayed to
// match the renderer latency, and a blanking output register for RGB.
module vga_sync_gen
  import vga_timing_pkg::*;
#(
  parameter int unsigned TOTAL_COLS      = VGA_TOTAL_COLS,
  parameter int unsigned TOTAL_ROWS      = VGA_TOTAL_ROWS,
  parameter int unsigned ACTIVE_COLS     = VGA_ACTIVE_COLS,
  parameter int unsigned ACTIVE_ROWS     = VGA_ACTIVE_ROWS,
  parameter int unsigned H_FRONT_PORCH   = VGA_H_FRONT_PORCH,
  parameter int unsigned H_SYNC_WIDTH    = VGA_H_SYNC_WIDTH,
  parameter int unsigned V_FRONT_PORCH   = VGA_V_FRONT_PORCH,
  parameter int unsigned V_SYNC_WIDTH    = VGA_V_SYNC_WIDTH,
  parameter logic        SYNC_ACTIVE_LOW = 1'b1,
  parameter int unsigned RENDER_DELAY    = 0
) (
  input  logic       i_Clk,
  input  logic       i_Rst_n,
  input  logic       i_Enable,
  input  logic [3:0] i_Red,
  input  logic [3:0] i_Grn,
  input  logic [3:0] i_Blu,
  output logic [9:0] o_Col_Count,
  output logic [9:0] o_Row_Count,
  output logic       o_Frame_Start,
  output logic       o_HSync,
  output logic       o_VSync,
  output logic       o_Active,
  output logic [3:0] o_Red_Video,
  output logic [3:0] o_Grn_Video,
  output logic [3:0] o_Blu_Video
);

  localparam logic [CNT_W-1:0] COL_LAST = CNT_W'(TOTAL_COLS - 1);
  localparam logic [CNT_W-1:0] ROW_LAST = CNT_W'(TOTAL_ROWS - 1);
  localparam logic [CNT_W-1:0] ACT_COLS = CNT_W'(ACTIVE_COLS);
  localparam logic [CNT_W-1:0] ACT_ROWS = CNT_W'(ACTIVE_ROWS);
  localparam logic [CNT_W-1:0] HS_START = CNT_W'(ACTIVE_COLS + H_FRONT_PORCH);
  localparam logic [CNT_W-1:0] HS_END   = CNT_W'(ACTIVE_COLS + H_FRONT_PORCH + H_SYNC_WIDTH);
  localparam logic [CNT_W-1:0] VS_START = CNT_W'(ACTIVE_ROWS + V_FRONT_PORCH);
  localparam logic [CNT_W-1:0] VS_END   = CNT_W'(ACTIVE_ROWS + V_FRONT_PORCH + V_SYNC_WIDTH);

  if (TOTAL_COLS > (1 << CNT_W) || TOTAL_ROWS > (1 << CNT_W)) begin : g_bad_total
    $error("vga_sync_gen: TOTAL_COLS/TOTAL_ROWS exceed the 10-bit counters");
  end
  if (ACTIVE_COLS + H_FRONT_PORCH + H_SYNC_WIDTH > TOTAL_COLS - 1) begin : g_bad_h
    $error("vga_sync_gen: horizontal active + porch + sync exceeds TOTAL_COLS-1");
  end
  if (ACTIVE_ROWS + V_FRONT_PORCH + V_SYNC_WIDTH > TOTAL_ROWS - 1) begin : g_bad_v
    $error("vga_sync_gen: vertical active + porch + sync exceeds TOTAL_ROWS-1");
  end
  if (RENDER_DELAY > 4) begin : g_bad_delay
    $error("vga_sync_gen: RENDER_DELAY must be 0..4");
  end

  // ---------------------------------------------------------------- counters
  logic [CNT_W-1:0] col_q, col_d;
  logic [CNT_W-1:0] row_q, row_d;

  always_comb begin
    col_d = col_q;
    row_d = row_q;
    if (!i_Enable) begin
      col_d = '0;
      row_d = '0;
    end else if (col_q == COL_LAST) begin
      col_d = '0;
      row_d = (row_q == ROW_LAST) ? '0 : row_q + CNT_W'(1);
    end else begin
      col_d = col_q + CNT_W'(1);
    end
  end

  always_ff @(posedge i_Clk or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      col_q <= '0;
      row_q <= '0;
    end else begin
      col_q <= col_d;
      row_q <= row_d;
    end
  end

  // Reset gates the decode so no frame pulse leaks out while held in reset.
  assign o_Frame_Start = i_Rst_n && i_Enable && (col_q == '0) && (row_q == '0);

  // ------------------------------------------------------------------ decode
  sync_bundle_t cur_bundle;
  sync_bundle_t dly_bundle;

  always_comb begin
    cur_bundle = SYNC_IDLE;
    if (i_Enable) begin
      cur_bundle.hs  = in_window(col_q, HS_START, HS_END);
      cur_bundle.vs  = in_window(row_q, VS_START, VS_END);
      cur_bundle.act = (col_q < ACT_COLS) && (row_q < ACT_ROWS);
    end
  end

  sync_delay_line #(
    .DEPTH     (RENDER_DELAY),
    .WIDTH     ($bits(sync_bundle_t)),
    .RESET_VAL (SYNC_IDLE)
  ) u_sync_delay (
    .clk   (i_Clk),
    .rst_n (i_Rst_n),
    .din   (cur_bundle),
    .dout  (dly_bundle)
  );

  // ------------------------------------------------------- output register
  logic       hsync_q, hsync_d;
  logic       vsync_q, vsync_d;
  logic       active_q, active_d;
  logic [3:0] red_q, red_d;
  logic [3:0] grn_q, grn_d;
  logic [3:0] blu_q, blu_d;

  always_comb begin
    hsync_d  = dly_bundle.hs ^ SYNC_ACTIVE_LOW;
    vsync_d  = dly_bundle.vs ^ SYNC_ACTIVE_LOW;
    active_d = dly_bundle.act;
    red_d    = '0;
    grn_d    = '0;
    blu_d    = '0;
    if (dly_bundle.act) begin
      red_d = i_Red;
      grn_d = i_Grn;
      blu_d = i_Blu;
    end
  end

  always_ff @(posedge i_Clk or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      hsync_q  <= SYNC_ACTIVE_LOW;
      vsync_q  <= SYNC_ACTIVE_LOW;
      active_q <= 1'b0;
      red_q    <= '0;
      grn_q    <= '0;
      blu_q    <= '0;
    end else begin
      hsync_q  <= hsync_d;
      vsync_q  <= vsync_d;
      active_q <= active_d;
      red_q    <= red_d;
      grn_q    <= grn_d;
      blu_q    <= blu_d;
    end
  end

  assign o_Col_Count = col_q;
  assign o_Row_Count = row_q;
  assign o_HSync     = hsync_q;
  assign o_VSync     = vsync_q;
  assign o_Active    = active_q;
  assign o_Red_Video = red_q;
  assign o_Grn_Video = grn_q;
  assign o_Blu_Video = blu_q;

endmodule

// File: tb/tb_vga_sync_gen.sv
// Bench for vga_sync_gen: a shrunken-timing instance checked every cycle
// against a linear-position model, plus a full 640x480 instance for timing.
module tb_vga_sync_gen;

  localparam int unsigned TC = 40, TR = 20, AC = 24, AR = 12;
  localparam int unsigned HFP = 4, HSW = 6, VFP = 2, VSW = 2, RD = 2;
  localparam int unsigned FRAME = TC * TR;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n, en;
  logic [3:0] red, grn, blu;
  logic [9:0] col, row;
  logic       fs, hs, vs, act;
  logic [3:0] rv, gv, bv;

  logic       rst0_n, en0;
  logic [9:0] col0, row0;
  logic       fs0, hs0, vs0, act0;
  logic [3:0] rv0, gv0, bv0;

  int checks = 0;
  int errors = 0;
  int mode   = 0;
  logic [9:0] c1 = '0, c2 = '0;
  logic done0;

  vga_sync_gen #(
    .TOTAL_COLS(TC), .TOTAL_ROWS(TR), .ACTIVE_COLS(AC), .ACTIVE_ROWS(AR),
    .H_FRONT_PORCH(HFP), .H_SYNC_WIDTH(HSW), .V_FRONT_PORCH(VFP), .V_SYNC_WIDTH(VSW),
    .SYNC_ACTIVE_LOW(1'b1), .RENDER_DELAY(RD)
  ) dut (
    .i_Clk(clk), .i_Rst_n(rst_n), .i_Enable(en),
    .i_Red(red), .i_Grn(grn), .i_Blu(blu),
    .o_Col_Count(col), .o_Row_Count(row), .o_Frame_Start(fs),
    .o_HSync(hs), .o_VSync(vs), .o_Active(act),
    .o_Red_Video(rv), .o_Grn_Video(gv), .o_Blu_Video(bv)
  );

  vga_sync_gen #(
    .RENDER_DELAY(0)
  ) dut0 (
    .i_Clk(clk), .i_Rst_n(rst0_n), .i_Enable(en0),
    .i_Red(4'hF), .i_Grn(4'h0), .i_Blu(4'h3),
    .o_Col_Count(col0), .o_Row_Count(row0), .o_Frame_Start(fs0),
    .o_HSync(hs0), .o_VSync(vs0), .o_Active(act0),
    .o_Red_Video(rv0), .o_Grn_Video(gv0), .o_Blu_Video(bv0)
  );

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  // Stimulus: constant red, a renderer echoing the column two clocks late, or random.
  always @(posedge clk) begin
    #1;
    case (mode)
      0:       {red, grn, blu} = {4'hF, 4'h0, 4'h0};
      1:       begin red = c2[3:0]; grn = row[3:0]; blu = 4'($urandom); end
      default: {red, grn, blu} = 12'($urandom);
    endcase
    c2 = c1;
    c1 = col;
  end

  // Reference model: a linear pixel position per enabled clock, and a queue
  // of the last RD+1 issued counts standing in for the alignment latency.
  typedef struct packed {
    logic        en;
    logic [31:0] pos;
  } rec_t;

  rec_t        hist[$];
  logic [11:0] last_rgb;
  int unsigned mpos;

  always @(negedge clk) begin
    logic [19:0] exp_c, got_c;
    logic [15:0] exp_o, got_o;
    rec_t        old;
    int unsigned oc, orow;
    logic        h, v, a;
    got_c = {col, row};
    got_o = {fs, hs, vs, act, rv, gv, bv};
    if (!rst_n) begin
      exp_c = '0;
      exp_o = {1'b0, 1'b1, 1'b1, 1'b0, 12'h000};
      mpos  = 0;
      hist.delete();
      for (int i = 0; i < RD + 1; i++) hist.push_back('{en: 1'b0, pos: 32'd0});
      last_rgb = '0;
    end else begin
      old  = hist[0];
      oc   = old.pos % TC;
      orow = old.pos / TC;
      h = old.en && (oc >= AC + HFP) && (oc < AC + HFP + HSW);
      v = old.en && (orow >= AR + VFP) && (orow < AR + VFP + VSW);
      a = old.en && (oc < AC) && (orow < AR);
      exp_c = {10'(mpos % TC), 10'(mpos / TC)};
      exp_o = {(en && mpos == 0), ~h, ~v, a, (a ? last_rgb : 12'h000)};
      void'(hist.pop_front());
      hist.push_back('{en: en, pos: mpos});
      last_rgb = {red, grn, blu};
      mpos = en ? (mpos + 1) % FRAME : 0;
    end
    check("counts", 32'(got_c), 32'(exp_c));
    check("outputs", 32'(got_o), 32'(exp_o));
  end

  // Full-size instance: hsync placement, width and line period.
  initial begin
    int fall, rise, fall2;
    logic prev_hs0, vs0_low;
    rst0_n = 1'b0; en0 = 1'b0; done0 = 1'b0;
    fall = -1; rise = -1; fall2 = -1; prev_hs0 = 1'b1; vs0_low = 1'b0;
    repeat (2) @(posedge clk);
    #1; en0 = 1'b1; rst0_n = 1'b1;
    @(negedge clk);
    check("d0_fs", 32'(fs0), 32'd1);
    for (int i = 0; i < 2000 && fall2 < 0; i++) begin
      if (i == 1) begin
        check("d0_act_first", 32'(act0), 32'd1);
        check("d0_red_first", 32'(rv0), 32'hF);
      end
      if (i == 640) check("d0_act_last", 32'(act0), 32'd1);
      if (i == 641) check("d0_act_off", 32'(act0), 32'd0);
      if (!vs0) vs0_low = 1'b1;
      if (!hs0 && prev_hs0) begin
        if (fall < 0) fall = i; else fall2 = i;
      end
      if (hs0 && !prev_hs0 && fall >= 0 && rise < 0) rise = i;
      prev_hs0 = hs0;
      @(negedge clk);
    end
    check("d0_hs_start", 32'(fall), 32'd657);
    check("d0_hs_width", 32'(rise - fall), 32'd96);
    check("d0_line_period", 32'(fall2 - fall), 32'd800);
    check("d0_vs_idle", 32'(vs0_low), 32'd0);
    done0 = 1'b1;
  end

  initial begin
    int n_fs, fs_pos, fs_gap, vs_low, red_f, red_bad, wraps, wrap_bad;
    logic [9:0] prev_col, prev_row;
    logic found, prev_act;
    rst_n = 1'b0; en = 1'b0; red = '0; grn = '0; blu = '0;
    n_fs = 0; fs_pos = 0; fs_gap = 0; vs_low = 0; red_f = 0; red_bad = 0;
    wraps = 0; wrap_bad = 0; prev_col = '0; prev_row = '0;

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_counts", 32'({col, row}), 32'd0);
    check("rst_sync", 32'({hs, vs}), 32'd3);
    check("rst_video", 32'({fs, act, rv, gv, bv}), 32'd0);
    @(posedge clk); #1; en = 1'b1;
    @(negedge clk);
    check("rst_fs_gated", 32'(fs), 32'd0);
    @(posedge clk); #1; rst_n = 1'b1;

    // Two frames with constant red.
    @(negedge clk);
    check("first_fs", 32'({fs, col, row}), 32'h100000);
    for (int i = 0; i < 2 * FRAME; i++) begin
      if (fs) begin
        if (n_fs == 1) fs_gap = i - fs_pos;
        fs_pos = i;
        n_fs++;
      end
      if (!vs) vs_low++;
      if (rv == 4'hF) red_f++;
      if (rv != 4'h0 && (!hs || !vs)) red_bad++;
      if (prev_col == 10'(TC - 1) && prev_row == 10'(TR - 1)) begin
        wraps++;
        if (col != 10'd0 || row != 10'd0) wrap_bad++;
      end
      prev_col = col;
      prev_row = row;
      @(negedge clk);
    end
    check("fs_count", 32'(n_fs), 32'd2);
    check("fs_period", 32'(fs_gap), 32'd800);
    check("vsync_low_clocks", 32'(vs_low), 32'd160);
    check("red_on_clocks", 32'(red_f), 32'd576);
    check("red_during_sync", 32'(red_bad), 32'd0);
    check("wrap_seen", 32'(wraps), 32'd1);
    check("wrap_to_origin", 32'(wrap_bad), 32'd0);

    // Renderer echoing the column two clocks late.
    @(posedge clk); #1; mode = 1;
    repeat (6) @(posedge clk);
    for (int line = 0; line < 2; line++) begin
      found = 1'b0;
      prev_act = 1'b1;
      for (int i = 0; i < 3 * TC; i++) begin
        @(negedge clk);
        if (act && !prev_act) begin found = 1'b1; break; end
        prev_act = act;
      end
      check("act_rise_found", 32'(found), 32'd1);
      if (found) begin
        check("first_pixel", 32'(rv), 32'd0);
        @(negedge clk);
        check("second_pixel", 32'(rv), 32'd1);
      end
    end

    // Random RGB with random enable drops and resets.
    @(posedge clk); #1; mode = 2;
    for (int i = 0; i < 3000; i++) begin
      @(posedge clk); #1;
      if ($urandom_range(0, 599) == 0) begin
        rst_n = 1'b0;
        repeat ($urandom_range(1, 3)) @(posedge clk);
        #1; rst_n = 1'b1;
      end else if (en && $urandom_range(0, 99) < 2) begin
        en = 1'b0;
      end else if (!en && $urandom_range(0, 99) < 20) begin
        en = 1'b1;
      end
    end

    // Reset mid-frame at count (30,10).
    @(posedge clk); #1; en = 1'b1; rst_n = 1'b1;
    found = 1'b0;
    for (int i = 0; i < 2 * FRAME + 2; i++) begin
      @(posedge clk); #1;
      if (col == 10'd30 && row == 10'd10) begin found = 1'b1; break; end
    end
    check("reach_30_10", 32'(found), 32'd1);
    rst_n = 1'b0;
    #1;
    check("async_counts", 32'({col, row}), 32'd0);
    check("async_outputs", 32'({fs, hs, vs, act, rv, gv, bv}), 32'h6000);
    repeat (3) @(posedge clk);
    #1; rst_n = 1'b1;
    #1;
    check("resume_fs", 32'({fs, col, row}), 32'h100000);
    @(posedge clk); #1;
    check("resume_next", 32'({fs, col, row}), 32'h00400);

    // Enable drop at count (30,14), inside both sync pulses.
    found = 1'b0;
    for (int i = 0; i < 2 * FRAME + 2; i++) begin
      @(posedge clk); #1;
      if (col == 10'd30 && row == 10'd14) begin found = 1'b1; break; end
    end
    check("reach_30_14", 32'(found), 32'd1);
    en = 1'b0;
    @(posedge clk); #1;
    check("dis_counts", 32'({col, row}), 32'd0);
    @(posedge clk); #1;
    check("dis_sync_lag", 32'({hs, vs}), 32'd0);
    @(posedge clk); #1;
    check("dis_idle", 32'({hs, vs, act, rv, gv, bv}), 32'h6000);
    @(posedge clk); #1; en = 1'b1;
    #1;
    check("reenable_fs", 32'({fs, col, row}), 32'h100000);
    repeat (100) @(posedge clk);

    for (int i = 0; i < 5000 && !done0; i++) @(posedge clk);
    check("dut0_done", 32'(done0), 32'd1);
    @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
